// File: rtl/reg_alu_pipe_if.sv
// Issue/write-back bus of the reg_alu_pipe datapath.
// The master side (decoder/controller, memory) presents the instruction fields
// and the load data. The slave side (the datapath) returns in_ready, the WB
// stage view, the registered ALU result and the PSR.
//   in_valid/in_ready      : issue handshake
//   write, imm_mux, cond_rslt, wb_mux, rSrc, rDst, alu_op, pc_ra, imm_in
//                          : instruction fields, sampled at acceptance
//   mem_data               : load data, sampled while the load sits in WB
//   wb_valid, wb_rdst, wb_data, alu_result, psr_out : datapath outputs
interface reg_alu_pipe_if #(
  parameter int DATAWIDTH = 16,
  parameter int NREGS     = 16,
  parameter int IMMWIDTH  = 8,
  parameter int PSRWIDTH  = 5
);
  localparam int REGW = $clog2(NREGS);

  logic                 in_valid;
  logic                 in_ready;
  logic                 write;
  logic                 imm_mux;
  logic                 cond_rslt;
  logic [1:0]           wb_mux;
  logic [REGW-1:0]      rSrc;
  logic [REGW-1:0]      rDst;
  logic [3:0]           alu_op;
  logic [DATAWIDTH-1:0] pc_ra;
  logic [IMMWIDTH-1:0]  imm_in;
  logic [DATAWIDTH-1:0] mem_data;
  logic                 wb_valid;
  logic [REGW-1:0]      wb_rdst;
  logic [DATAWIDTH-1:0] wb_data;
  logic [DATAWIDTH-1:0] alu_result;
  logic [PSRWIDTH-1:0]  psr_out;

  modport master (
    output in_valid, write, imm_mux, cond_rslt, wb_mux, rSrc, rDst, alu_op,
           pc_ra, imm_in, mem_data,
    input  in_ready, wb_valid, wb_rdst, wb_data, alu_result, psr_out
  );

  modport slave (
    input  in_valid, write, imm_mux, cond_rslt, wb_mux, rSrc, rDst, alu_op,
           pc_ra, imm_in, mem_data,
    output in_ready, wb_valid, wb_rdst, wb_data, alu_result, psr_out
  );
endinterface

// File: rtl/reg_alu_pipe.sv
// Three-stage (issue/read, execute, write-back) register file + ALU pipeline.
// Operand A is always reg[rDst]; operand B is reg[rSrc] or the sign-extended
// immediate. Full EX/WB forwarding, a registered PSR {N,Z,F,L,C}, and a
// one-cycle interlock when an instruction needs the result of a load in EX.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : reg_alu_pipe_if slave (issue handshake, fields, WB outputs)
module reg_alu_pipe #(
  parameter int DATAWIDTH = 16,
  parameter int NREGS     = 16,
  parameter int IMMWIDTH  = 8,
  parameter int PSRWIDTH  = 5
) (
  input  logic          clk,
  input  logic          reset,
  reg_alu_pipe_if.slave bus
);
  localparam int REGW = $clog2(NREGS);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;

  logic [DATAWIDTH-1:0] rf [NREGS];

  logic                 ex_valid, ex_write, ex_cond;
  logic [1:0]           ex_wb_mux;
  logic [REGW-1:0]      ex_dst;
  logic [3:0]           ex_op;
  logic [DATAWIDTH-1:0] ex_a, ex_b, ex_pc_ra;

  logic                 wb_valid_q, wb_write, wb_cond;
  logic [1:0]           wb_mux_q;
  logic [REGW-1:0]      wb_rdst_q;
  logic [DATAWIDTH-1:0] alu_result_q, wb_pc_ra;
  logic [PSRWIDTH-1:0]  psr_q;

  logic [DATAWIDTH-1:0] alu_r, ex_fwd, wb_data_c, opnd_a, opnd_b, imm_ext;
  logic [DATAWIDTH:0]   sum, diff;
  logic                 load_hit, accept;
  logic [3:0]           shamt_neg;

  assign imm_ext = {{(DATAWIDTH-IMMWIDTH){bus.imm_in[IMMWIDTH-1]}}, bus.imm_in};

  // An instruction that reads the destination of a load still in EX must wait
  // one cycle so the load data can be picked up from the WB path.
  assign load_hit = ex_valid && ex_write && (ex_wb_mux == 2'd3) &&
                    ((ex_dst == bus.rDst) || (!bus.imm_mux && (ex_dst == bus.rSrc)));
  assign bus.in_ready = !load_hit;
  assign accept = bus.in_valid && !load_hit;

  // ALU; the low bits of -B only depend on the low bits of B
  assign shamt_neg = 4'd0 - ex_b[3:0];
  always_comb begin
    sum   = {1'b0, ex_a} + {1'b0, ex_b};
    diff  = {1'b0, ex_a} - {1'b0, ex_b};
    alu_r = '0;
    case (ex_op)
      OP_ADD: alu_r = sum[DATAWIDTH-1:0];
      OP_SUB, OP_CMP: alu_r = diff[DATAWIDTH-1:0];
      OP_AND: alu_r = ex_a & ex_b;
      OP_OR:  alu_r = ex_a | ex_b;
      OP_XOR: alu_r = ex_a ^ ex_b;
      OP_MOV: alu_r = ex_b;
      OP_LSH: alu_r = ex_b[DATAWIDTH-1] ? (ex_a >> shamt_neg) : (ex_a << ex_b[3:0]);
      default: alu_r = '0;
    endcase
  end

  // Value the EX instruction will write back (loads are excluded via the interlock)
  always_comb begin
    ex_fwd = alu_r;
    case (ex_wb_mux)
      2'd0: ex_fwd = ex_pc_ra;
      2'd1: ex_fwd = {{(DATAWIDTH-1){1'b0}}, ex_cond};
      default: ex_fwd = alu_r;
    endcase
  end

  always_comb begin
    wb_data_c = alu_result_q;
    case (wb_mux_q)
      2'd0: wb_data_c = wb_pc_ra;
      2'd1: wb_data_c = {{(DATAWIDTH-1){1'b0}}, wb_cond};
      2'd2: wb_data_c = alu_result_q;
      default: wb_data_c = bus.mem_data;
    endcase
  end

  // Operand read with EX-over-WB-over-regfile priority
  always_comb begin
    opnd_a = rf[bus.rDst];
    if (ex_valid && ex_write && ex_wb_mux != 2'd3 && ex_dst == bus.rDst)
      opnd_a = ex_fwd;
    else if (wb_valid_q && wb_write && wb_rdst_q == bus.rDst)
      opnd_a = wb_data_c;

    opnd_b = rf[bus.rSrc];
    if (bus.imm_mux)
      opnd_b = imm_ext;
    else if (ex_valid && ex_write && ex_wb_mux != 2'd3 && ex_dst == bus.rSrc)
      opnd_b = ex_fwd;
    else if (wb_valid_q && wb_write && wb_rdst_q == bus.rSrc)
      opnd_b = wb_data_c;
  end

  // Pipeline registers, flags and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_write     <= 1'b0;
      ex_cond      <= 1'b0;
      ex_wb_mux    <= '0;
      ex_dst       <= '0;
      ex_op        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_pc_ra     <= '0;
      wb_valid_q   <= 1'b0;
      wb_write     <= 1'b0;
      wb_cond      <= 1'b0;
      wb_mux_q     <= '0;
      wb_rdst_q    <= '0;
      alu_result_q <= '0;
      wb_pc_ra     <= '0;
      psr_q        <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_write  <= bus.write && (bus.alu_op != OP_CMP);
        ex_cond   <= bus.cond_rslt;
        ex_wb_mux <= bus.wb_mux;
        ex_dst    <= bus.rDst;
        ex_op     <= bus.alu_op;
        ex_a      <= opnd_a;
        ex_b      <= opnd_b;
        ex_pc_ra  <= bus.pc_ra;
      end

      wb_valid_q <= ex_valid;
      if (ex_valid) begin
        wb_write     <= ex_write;
        wb_cond      <= ex_cond;
        wb_mux_q     <= ex_wb_mux;
        wb_rdst_q    <= ex_dst;
        alu_result_q <= alu_r;
        wb_pc_ra     <= ex_pc_ra;
      end

      // PSR order {N,Z,F,L,C}; C is carry for ADD and borrow for SUB/CMP
      if (ex_valid && (ex_op == OP_ADD || ex_op == OP_SUB || ex_op == OP_CMP)) begin
        psr_q <= {
          $signed(ex_a) < $signed(ex_b),
          (ex_op == OP_CMP) ? (ex_a == ex_b) : (alu_r == '0),
          (ex_op == OP_ADD) ?
            ((ex_a[DATAWIDTH-1] == ex_b[DATAWIDTH-1]) && (alu_r[DATAWIDTH-1] != ex_a[DATAWIDTH-1])) :
            ((ex_a[DATAWIDTH-1] != ex_b[DATAWIDTH-1]) && (alu_r[DATAWIDTH-1] != ex_a[DATAWIDTH-1])),
          ex_a < ex_b,
          (ex_op == OP_ADD) ? sum[DATAWIDTH] : diff[DATAWIDTH]
        };
      end

      if (wb_valid_q && wb_write)
        rf[wb_rdst_q] <= wb_data_c;
    end
  end

  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rdst    = wb_rdst_q;
  assign bus.wb_data    = wb_data_c;
  assign bus.alu_result = alu_result_q;
  assign bus.psr_out    = psr_q;
endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed-vector bench for reg_alu_pipe: a 16-bit instance for the main
// scenarios and a 32-bit/32-register instance for the width sweep.
module tb_reg_alu_pipe;
  logic clk;
  logic reset;
  int checkCount;
  int errorCount;

  reg_alu_pipe_if #(.DATAWIDTH(16), .NREGS(16), .IMMWIDTH(8), .PSRWIDTH(5)) bus ();
  reg_alu_pipe_if #(.DATAWIDTH(32), .NREGS(32), .IMMWIDTH(8), .PSRWIDTH(5)) bus32 ();

  reg_alu_pipe #(.DATAWIDTH(16), .NREGS(16), .IMMWIDTH(8), .PSRWIDTH(5)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  reg_alu_pipe #(.DATAWIDTH(32), .NREGS(32), .IMMWIDTH(8), .PSRWIDTH(5)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, CMP = 4'd2, XOR = 4'd5, MOV = 4'd6, LSH = 4'd7;

  // Single comparison point: counts the check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one instruction and hold it until accepted; returns stall cycles.
  // Returns 1 ns after the accepting edge, i.e. while the instruction is in EX.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] src,
                               input logic useImm, input logic [7:0] imm, input logic wr,
                               input logic [1:0] wbm, output int stalls);
    bus.alu_op = op; bus.rDst = dst; bus.rSrc = src; bus.imm_mux = useImm;
    bus.imm_in = imm; bus.write = wr; bus.wb_mux = wbm; bus.in_valid = 1'b1;
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
    end
    if (stalls >= 10) checkOutput("issue_timeout", 32'(stalls), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Read a register by issuing a non-writing MOV and observing alu_result in WB
  task automatic readReg(input logic [3:0] r, output logic [15:0] val);
    int s;
    applyStimulus(MOV, 4'd0, r, 1'b0, 8'h00, 1'b0, 2'd2, s);
    @(posedge clk); #1;
    val = bus.alu_result;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [15:0] v;
    int s, stallSum;
    checkCount = 0; errorCount = 0;
    bus.in_valid = 0; bus.write = 0; bus.imm_mux = 0; bus.cond_rslt = 0; bus.wb_mux = 0;
    bus.rSrc = 0; bus.rDst = 0; bus.alu_op = 0; bus.pc_ra = 0; bus.imm_in = 0; bus.mem_data = 0;
    bus32.in_valid = 0; bus32.write = 0; bus32.imm_mux = 0; bus32.cond_rslt = 0; bus32.wb_mux = 0;
    bus32.rSrc = 0; bus32.rDst = 0; bus32.alu_op = 0; bus32.pc_ra = 0; bus32.imm_in = 0; bus32.mem_data = 0;
    reset = 1'b1;
    #22 reset = 1'b0;
    @(posedge clk); #1;

    checkOutput("reset_psr", 32'(bus.psr_out), 32'h0);
    checkOutput("reset_wb_valid", 32'(bus.wb_valid), 32'h0);
    checkOutput("reset_alu_result", 32'(bus.alu_result), 32'h0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h1);

    // MOV r1,#5 ; MOV r2,#-3 ; ADD r1,r2 back to back
    stallSum = 0;
    applyStimulus(MOV, 4'd1, 4'd0, 1'b1, 8'h05, 1'b1, 2'd2, s); stallSum += s;
    applyStimulus(MOV, 4'd2, 4'd0, 1'b1, 8'hFD, 1'b1, 2'd2, s); stallSum += s;
    applyStimulus(ADD, 4'd1, 4'd2, 1'b0, 8'h00, 1'b1, 2'd2, s); stallSum += s;
    @(posedge clk); #1;
    checkOutput("add_alu_result", 32'(bus.alu_result), 32'h0002);
    checkOutput("add_psr", 32'(bus.psr_out), 32'b00011);
    checkOutput("add_stalls", 32'(stallSum), 32'd0);
    idle(1);
    readReg(4'd1, v); checkOutput("add_r1", 32'(v), 32'h0002);
    readReg(4'd2, v); checkOutput("mov_r2", 32'(v), 32'hFFFD);

    // Reset with an ADD in EX
    applyStimulus(ADD, 4'd7, 4'd0, 1'b1, 8'h01, 1'b1, 2'd2, s);
    reset = 1'b1; #2 reset = 1'b0; #1;
    checkOutput("midreset_psr", 32'(bus.psr_out), 32'h0);
    checkOutput("midreset_wb_valid", 32'(bus.wb_valid), 32'h0);
    idle(3);
    readReg(4'd7, v); checkOutput("midreset_r7", 32'(v), 32'h0);
    readReg(4'd1, v); checkOutput("midreset_r1", 32'(v), 32'h0);

    // Dependent chain through EX then WB forwarding
    stallSum = 0;
    applyStimulus(MOV, 4'd3, 4'd0, 1'b1, 8'h7F, 1'b1, 2'd2, s); stallSum += s;
    applyStimulus(ADD, 4'd3, 4'd3, 1'b0, 8'h00, 1'b1, 2'd2, s); stallSum += s;
    applyStimulus(ADD, 4'd3, 4'd3, 1'b0, 8'h00, 1'b1, 2'd2, s); stallSum += s;
    checkOutput("chain_stalls", 32'(stallSum), 32'd0);
    idle(2);
    readReg(4'd3, v); checkOutput("chain_r3", 32'(v), 32'h01FC);

    // Write-back of cond bit and return address, then combined through forwarding
    bus.cond_rslt = 1'b1;
    applyStimulus(MOV, 4'd10, 4'd0, 1'b1, 8'h00, 1'b1, 2'd1, s);
    bus.cond_rslt = 1'b0; bus.pc_ra = 16'h1234;
    applyStimulus(MOV, 4'd11, 4'd0, 1'b1, 8'h00, 1'b1, 2'd0, s);
    bus.pc_ra = 16'h0000;
    applyStimulus(ADD, 4'd11, 4'd10, 1'b0, 8'h00, 1'b1, 2'd2, s);
    idle(2);
    readReg(4'd10, v); checkOutput("cond_r10", 32'(v), 32'h0001);
    readReg(4'd11, v); checkOutput("pcra_add_r11", 32'(v), 32'h1235);

    // Load-use interlock
    applyStimulus(MOV, 4'd5, 4'd0, 1'b1, 8'h12, 1'b1, 2'd2, s);
    bus.mem_data = 16'hBEEF;
    applyStimulus(MOV, 4'd4, 4'd0, 1'b1, 8'h00, 1'b1, 2'd3, s);
    applyStimulus(XOR, 4'd5, 4'd4, 1'b0, 8'h00, 1'b1, 2'd2, s);
    checkOutput("loaduse_stalls", 32'(s), 32'd1);
    idle(2);
    readReg(4'd5, v); checkOutput("loaduse_r5", 32'(v), 32'hBEFD);
    readReg(4'd4, v); checkOutput("load_r4", 32'(v), 32'hBEEF);
    // Immediate B does not depend on the load destination
    applyStimulus(MOV, 4'd4, 4'd0, 1'b1, 8'h00, 1'b1, 2'd3, s);
    applyStimulus(ADD, 4'd6, 4'd4, 1'b1, 8'h01, 1'b1, 2'd2, s);
    checkOutput("imm_nostall", 32'(s), 32'd0);
    bus.mem_data = 16'h0000;
    idle(2);

    // CMP 0x8000 vs 1; write requested but must be suppressed
    applyStimulus(MOV, 4'd8, 4'd0, 1'b1, 8'h01, 1'b1, 2'd2, s);
    applyStimulus(LSH, 4'd8, 4'd0, 1'b1, 8'h0F, 1'b1, 2'd2, s);
    applyStimulus(CMP, 4'd8, 4'd0, 1'b1, 8'h01, 1'b1, 2'd2, s);
    @(posedge clk); #1;
    checkOutput("cmp_psr", 32'(bus.psr_out), 32'b10100);
    idle(1);
    readReg(4'd8, v); checkOutput("cmp_r8_unchanged", 32'(v), 32'h8000);

    // Negative shift is a logical right shift; flags untouched
    applyStimulus(MOV, 4'd9, 4'd0, 1'b1, 8'h40, 1'b1, 2'd2, s);
    applyStimulus(LSH, 4'd9, 4'd0, 1'b1, 8'hFE, 1'b1, 2'd2, s);
    idle(2);
    readReg(4'd9, v); checkOutput("lsh_right_r9", 32'(v), 32'h0010);
    checkOutput("lsh_psr_kept", 32'(bus.psr_out), 32'b10100);

    // 32-bit instance: SUB 0 - 1
    bus32.alu_op = SUB; bus32.rDst = 5'd0; bus32.imm_mux = 1'b1; bus32.imm_in = 8'h01;
    bus32.write = 1'b0; bus32.wb_mux = 2'd2; bus32.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("w32_in_ready", 32'(bus32.in_ready), 32'h1);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("w32_sub_result", bus32.alu_result, 32'hFFFFFFFF);
    checkOutput("w32_sub_psr", 32'(bus32.psr_out), 32'b10011);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
